// File: rtl/fetch_sequencer.sv
// PC owner and fetch sequencer for the two-stage RV32I core: drives the
// instruction fetch, takes EX redirects, and adds run/halt/step control.
//
// state | meaning
// ------+--------------------------------------------------------------
// RUN   | free-running fetch, pc_f advances by 4 every cycle
// HALT  | no fetch, pc_f held; waits for run_en or a step pulse
// STEP  | issues exactly one fetch, then returns to HALT
// FAULT | misaligned redirect seen; frozen until reset
module fetch_sequencer #(
    parameter int          IMEM_AW  = 6,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run_en,
    input  logic               step,
    input  logic               pc_src_ex,
    input  logic [31:0]        target_ex,
    output logic [31:0]        pc_f,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic               fetch_valid,
    output logic               ex_valid,
    output logic [31:0]        pc_ex,
    output logic               halted,
    output logic               fault,
    output logic [31:0]        fault_addr,
    output logic [31:0]        retired_cnt,
    output logic [31:0]        bubble_cnt
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_HALT  = 2'd1,
        S_STEP  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        redirect;
    logic        target_misaligned;
    logic [31:0] pc_nxt;

    assign imem_addr = pc_f[IMEM_AW+1:2];

    // A redirect overrides whatever the current state would fetch; the
    // state itself only changes on a misaligned target.
    always_comb begin
        redirect          = ex_valid && pc_src_ex && (state != S_FAULT);
        target_misaligned = (target_ex[1:0] != 2'b00);
        fetch_valid       = 1'b0;
        state_nxt         = state;
        pc_nxt            = pc_f;
        if (redirect) begin
            if (target_misaligned) begin
                state_nxt = S_FAULT;
            end else begin
                pc_nxt = target_ex;
            end
        end else begin
            case (state)
                S_RUN: begin
                    if (run_en) begin
                        fetch_valid = 1'b1;
                        pc_nxt      = pc_f + 32'd4;
                    end else begin
                        state_nxt = S_HALT;
                    end
                end
                S_HALT: begin
                    if (run_en) begin
                        state_nxt = S_RUN;
                    end else if (step) begin
                        state_nxt = S_STEP;
                    end
                end
                S_STEP: begin
                    fetch_valid = 1'b1;
                    pc_nxt      = pc_f + 32'd4;
                    state_nxt   = S_HALT;
                end
                default: begin
                    state_nxt = S_FAULT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_RUN;
            halted      <= 1'b0;
            fault       <= 1'b0;
            pc_f        <= RESET_PC;
            pc_ex       <= RESET_PC;
            ex_valid    <= 1'b0;
            fault_addr  <= 32'h0000_0000;
            retired_cnt <= 32'h0000_0000;
            bubble_cnt  <= 32'h0000_0000;
        end else begin
            state    <= state_nxt;
            halted   <= (state_nxt == S_HALT) || (state_nxt == S_FAULT);
            fault    <= (state_nxt == S_FAULT);
            pc_f     <= pc_nxt;
            ex_valid <= fetch_valid;
            if (fetch_valid) begin
                pc_ex <= pc_f;
            end
            if (redirect && target_misaligned) begin
                fault_addr <= target_ex;
            end
            // Both counters stick at all-ones rather than wrapping.
            if (ex_valid && (retired_cnt != 32'hFFFF_FFFF)) begin
                retired_cnt <= retired_cnt + 32'd1;
            end
            if ((state == S_RUN) && !fetch_valid && (bubble_cnt != 32'hFFFF_FFFF)) begin
                bubble_cnt <= bubble_cnt + 32'd1;
            end
        end
    end

endmodule
